// File: rtl/avalon_body_regfile.sv
`default_nettype none
// ============================================================================
// avalon_body_regfile : N-body constant/state register file shared by the
//   Avalon-MM host and the physics engine, plus frame start, pause and pan.
//   Optional: GRAV_ACC_AUTOCLEAR_EN clears all ACC words on each engine start.
// Revision: 1.0
// ============================================================================
module avalon_body_regfile #(
  parameter int N_BODIES   = 10,
  parameter int ADDR_W     = 8,
  parameter int SHIFT_STEP = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  input  logic              ENG_RE,
  input  logic              ENG_WE,
  input  logic [ADDR_W-1:0] ENG_ADDR,
  input  logic [31:0]       ENG_WDATA,
  output logic [31:0]       ENG_RDATA,
  output logic              ENG_WAIT,
  output logic              ENG_START,
  input  logic              ENG_DONE,
  input  logic              VGA_VS,
  input  logic [7:0]        keycode,
  output logic [31:0]       SHIFT_X,
  output logic [31:0]       SHIFT_Y,
  output logic [31:0]       SHIFT_Z,
  output logic              PAUSED,
  output logic [31:0]       EXPORT_DATA
);

  localparam int DEPTH    = 4 + 11 * N_BODIES;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int ACC_BASE = 4 + 8 * N_BODIES;

  localparam logic [ADDR_W:0]   c_DEPTH      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ADDR_STAT  = ADDR_W'(3);
  localparam logic [7:0]        c_KEY_SPACE  = 8'd44;
  localparam logic [7:0]        c_KEY_W      = 8'd26;
  localparam logic [7:0]        c_KEY_S      = 8'd22;
  localparam logic [7:0]        c_KEY_A      = 8'd4;
  localparam logic [7:0]        c_KEY_D      = 8'd7;
  localparam logic [7:0]        c_KEY_PGUP   = 8'd75;
  localparam logic [7:0]        c_KEY_PGDN   = 8'd78;
  localparam logic [31:0]       c_STEP       = 32'(SHIFT_STEP);

  logic [31:0]      r_mem [DEPTH];
  logic             r_done, r_busy, r_paused, r_eng_start;
  logic [7:0]       r_overrun, r_prev_key;
  logic             r_vs1, r_vs2;
  logic [31:0]      r_shift_x, r_shift_y, r_shift_z;
  logic [31:0]      r_avl_rdata, r_eng_rdata;

  logic             w_host_wr, w_host_in, w_host_stat;
  logic             w_eng_in, w_eng_wr, w_eng_rd;
  logic [IDX_W-1:0] w_host_idx, w_eng_idx;
  logic [31:0]      w_status, w_host_rdval, w_eng_rdval;
  logic             w_frame_rise, w_start_req;

  assign w_host_wr   = AVL_CS && AVL_WRITE;
  assign w_host_in   = {1'b0, AVL_ADDR} < c_DEPTH;
  assign w_host_stat = AVL_ADDR == c_ADDR_STAT;
  assign w_host_idx  = AVL_ADDR[IDX_W-1:0];
  assign w_eng_in    = {1'b0, ENG_ADDR} < c_DEPTH;
  assign w_eng_idx   = ENG_ADDR[IDX_W-1:0];

  // Host writes take the single write port; host reads never stall the engine.
  assign ENG_WAIT = w_host_wr && (ENG_RE || ENG_WE);
  assign w_eng_wr = ENG_WE && !ENG_WAIT && w_eng_in && (ENG_ADDR != c_ADDR_STAT);
  assign w_eng_rd = ENG_RE && !ENG_WAIT;

  assign w_status     = {16'd0, r_overrun, 5'd0, r_paused, r_busy, r_done};
  assign w_frame_rise = r_vs1 && !r_vs2;
  assign w_start_req  = w_frame_rise && !r_paused && r_mem[2][0];

  always_comb begin
    w_host_rdval = '0;
    if (w_host_in)
      w_host_rdval = w_host_stat ? w_status : r_mem[w_host_idx];
  end

  always_comb begin
    w_eng_rdval = '0;
    if (w_eng_in)
      w_eng_rdval = (ENG_ADDR == c_ADDR_STAT) ? w_status : r_mem[w_eng_idx];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[IDX_W'(i)] <= '0;
    end else begin
      if (w_host_wr && w_host_in && !w_host_stat) begin
        for (int b = 0; b < 4; b++)
          if (AVL_BYTE_EN[b]) r_mem[w_host_idx][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
      end
      if (w_eng_wr) r_mem[w_eng_idx] <= ENG_WDATA;
`ifdef GRAV_ACC_AUTOCLEAR_EN
      // Clear is last so it overrides any same-cycle write to an ACC word.
      if (r_eng_start)
        for (int i = 0; i < 3 * N_BODIES; i++) r_mem[IDX_W'(ACC_BASE + i)] <= '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_avl_rdata <= '0;
      r_eng_rdata <= '0;
    end else begin
      r_avl_rdata <= (AVL_CS && AVL_READ) ? w_host_rdval : '0;
      if (w_eng_rd) r_eng_rdata <= w_eng_rdval;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vs1       <= 1'b0;
      r_vs2       <= 1'b0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= '0;
    end else begin
      r_vs1       <= VGA_VS;
      r_vs2       <= r_vs1;
      r_eng_start <= w_start_req && !r_busy;
      if (w_start_req && !r_busy) r_busy <= 1'b1;
      else if (ENG_DONE)          r_busy <= 1'b0;
      if (ENG_DONE)
        r_done <= 1'b1;
      else if (w_host_wr && w_host_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[0])
        r_done <= 1'b0;
      if (w_host_wr && w_host_stat && AVL_BYTE_EN[1])
        r_overrun <= '0;
      else if (w_start_req && r_busy && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_paused   <= 1'b1;
      r_prev_key <= '0;
      r_shift_x  <= '0;
      r_shift_y  <= '0;
      r_shift_z  <= '0;
    end else begin
      r_prev_key <= keycode;
      if (keycode == c_KEY_SPACE && r_prev_key != c_KEY_SPACE) r_paused <= !r_paused;
      if (w_frame_rise) begin
        if (keycode == c_KEY_W)    r_shift_y <= r_shift_y - c_STEP;
        if (keycode == c_KEY_S)    r_shift_y <= r_shift_y + c_STEP;
        if (keycode == c_KEY_A)    r_shift_x <= r_shift_x - c_STEP;
        if (keycode == c_KEY_D)    r_shift_x <= r_shift_x + c_STEP;
        if (keycode == c_KEY_PGUP) r_shift_z <= r_shift_z + c_STEP;
        if (keycode == c_KEY_PGDN) r_shift_z <= r_shift_z - c_STEP;
      end
    end
  end

  assign AVL_READDATA = r_avl_rdata;
  assign ENG_RDATA    = r_eng_rdata;
  assign ENG_START    = r_eng_start;
  assign SHIFT_X      = r_shift_x;
  assign SHIFT_Y      = r_shift_y;
  assign SHIFT_Z      = r_shift_z;
  assign PAUSED       = r_paused;
  assign EXPORT_DATA  = {keycode, r_mem[1][7:0], r_overrun, 5'd0, r_paused, r_busy, r_done};

endmodule
`default_nettype wire

// File: tb/tb_avalon_body_regfile.sv
`default_nettype none
// Directed self-checking bench for avalon_body_regfile (default parameters).
module tb_avalon_body_regfile;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        AVL_CS = 0, AVL_READ = 0, AVL_WRITE = 0;
  logic [3:0]  AVL_BYTE_EN = 0;
  logic [7:0]  AVL_ADDR = 0;
  logic [31:0] AVL_WRITEDATA = 0, AVL_READDATA;
  logic        ENG_RE = 0, ENG_WE = 0;
  logic [7:0]  ENG_ADDR = 0;
  logic [31:0] ENG_WDATA = 0, ENG_RDATA;
  logic        ENG_WAIT, ENG_START, ENG_DONE = 0, VGA_VS = 0;
  logic [7:0]  keycode = 0;
  logic [31:0] SHIFT_X, SHIFT_Y, SHIFT_Z, EXPORT_DATA;
  logic        PAUSED;

  avalon_body_regfile dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .ENG_RE(ENG_RE), .ENG_WE(ENG_WE), .ENG_ADDR(ENG_ADDR),
    .ENG_WDATA(ENG_WDATA), .ENG_RDATA(ENG_RDATA), .ENG_WAIT(ENG_WAIT),
    .ENG_START(ENG_START), .ENG_DONE(ENG_DONE), .VGA_VS(VGA_VS),
    .keycode(keycode), .SHIFT_X(SHIFT_X), .SHIFT_Y(SHIFT_Y), .SHIFT_Z(SHIFT_Z),
    .PAUSED(PAUSED), .EXPORT_DATA(EXPORT_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = d;
    tick;
    AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
    tick;
    AVL_CS = 0; AVL_READ = 0;
    d = AVL_READDATA;
  endtask

  task automatic done_pulse;
    ENG_DONE = 1;
    tick;
    ENG_DONE = 0;
  endtask

  task automatic press_space;
    keycode = 8'd44; tick; tick;
    keycode = 8'd0;  tick;
  endtask

  task automatic frame(output int starts);
    starts = 0;
    VGA_VS = 1;
    repeat (5) begin tick; if (ENG_START) starts++; end
    VGA_VS = 0;
    repeat (3) begin tick; if (ENG_START) starts++; end
  endtask

  logic [31:0] rd;
  int          st;

  initial begin
    vecs[0] = '{8'd5,   4'b0101, 32'hAABBCCDD, 32'h00BB00DD};
    vecs[1] = '{8'd5,   4'b1010, 32'h11223344, 32'h11BB33DD};
    vecs[2] = '{8'd0,   4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{8'd113, 4'b1111, 32'h12345678, 32'h12345678};
    vecs[4] = '{8'd114, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
    vecs[5] = '{8'd1,   4'b0001, 32'h0000000A, 32'h0000000A};
    vecs[6] = '{8'd3,   4'b0010, 32'h0000FFFF, 32'h00000004};

    repeat (3) tick;
    RESET = 0;
    check("rst_paused", {31'd0, PAUSED}, 32'd1);
    check("rst_start", {31'd0, ENG_START}, 32'd0);
    check("rst_shift_x", SHIFT_X, 32'd0);
    check("rst_export", EXPORT_DATA, 32'h00000004);

    // Read latency: data appears only after the edge, and for one cycle.
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 8'd3; #1;
    check("rd_before_edge", AVL_READDATA, 32'd0);
    tick;
    AVL_CS = 0; AVL_READ = 0;
    check("rd_status_reset", AVL_READDATA, 32'h00000004);
    tick;
    check("rd_idle_zero", AVL_READDATA, 32'd0);
    host_read(8'd200, rd);
    check("rd_out_of_range", rd, 32'd0);

    foreach (vecs[i]) begin
      host_write(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      host_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end
    check("export_num", EXPORT_DATA, 32'h000A0004);

    // Engine read, then hold without new requests.
    ENG_RE = 1; ENG_ADDR = 8'd0; tick;
    ENG_RE = 0; ENG_ADDR = 8'd5;
    check("eng_rdata", ENG_RDATA, 32'hDEADBEEF);
    tick;
    check("eng_rdata_hold", ENG_RDATA, 32'hDEADBEEF);

    // Host and engine write collide: host first, engine the next cycle.
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 8'd6; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'h55;
    ENG_WE = 1; ENG_ADDR = 8'd7; ENG_WDATA = 32'h77; #1;
    check("eng_wait_high", {31'd0, ENG_WAIT}, 32'd1);
    tick;
    AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0; #1;
    check("eng_wait_low", {31'd0, ENG_WAIT}, 32'd0);
    tick;
    ENG_WE = 0;
    host_read(8'd6, rd); check("arb_host_data", rd, 32'h55);
    host_read(8'd7, rd); check("arb_eng_data", rd, 32'h77);
    ENG_WE = 1; ENG_ADDR = 8'd3; ENG_WDATA = 32'hFFFFFFFF; tick; ENG_WE = 0;
    host_read(8'd3, rd); check("eng_wr_status_ignored", rd, 32'h00000004);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 8'd0; ENG_RE = 1; #1;
    check("host_read_no_stall", {31'd0, ENG_WAIT}, 32'd0);
    tick;
    AVL_CS = 0; AVL_READ = 0; ENG_RE = 0;

    // Start / busy / overrun / done.
    host_write(8'd2, 4'hF, 32'd1);
    press_space;
    check("unpaused", {31'd0, PAUSED}, 32'd0);
    frame(st); check("frame1_starts", st, 1);
    host_read(8'd3, rd); check("status_busy", rd, 32'h00000002);
    frame(st); check("frame2_starts", st, 0);
    host_read(8'd3, rd); check("status_overrun", rd, 32'h00000102);
    done_pulse;
    host_read(8'd3, rd); check("status_done", rd, 32'h00000101);
    host_write(8'd3, 4'b0001, 32'd1);
    host_read(8'd3, rd); check("status_done_clr", rd, 32'h00000100);
    host_write(8'd3, 4'b0010, 32'd0);
    host_read(8'd3, rd); check("status_ovr_clr", rd, 32'h00000000);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 8'd3; AVL_BYTE_EN = 4'b0001; AVL_WRITEDATA = 32'd1;
    ENG_DONE = 1; tick;
    AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0; ENG_DONE = 0;
    host_read(8'd3, rd); check("done_set_wins", rd, 32'h00000001);

    // ACC_Z of the last body (addr 113) holds 0x12345678.
    frame(st); check("frame3_starts", st, 1);
    host_read(8'd113, rd);
`ifdef GRAV_ACC_AUTOCLEAR_EN
    check("acc_autoclear", rd, 32'h00000000);
`else
    check("acc_retained", rd, 32'h12345678);
`endif
    done_pulse;

    press_space;
    check("paused_again", {31'd0, PAUSED}, 32'd1);
    frame(st); check("paused_no_start", st, 0);
    host_read(8'd3, rd); check("paused_status", rd, 32'h00000005);
    press_space;

    // Pan: 9 frames, first starts the engine, the other 8 overrun.
    keycode = 8'd7;  repeat (3) frame(st);
    check("shift_x_plus3", SHIFT_X, 32'd3);
    keycode = 8'd4;  repeat (4) frame(st);
    check("shift_x_wrap", SHIFT_X, 32'hFFFFFFFF);
    keycode = 8'd75; frame(st);
    check("shift_z_up", SHIFT_Z, 32'd1);
    keycode = 8'd26; frame(st);
    check("shift_y_up", SHIFT_Y, 32'hFFFFFFFF);
    check("export_full", EXPORT_DATA, 32'h1A0A0803);
    keycode = 8'd0;

    // Reset while busy: the late DONE only sets DONE.
    RESET = 1; tick; tick; RESET = 0;
    host_read(8'd3, rd); check("post_rst_status", rd, 32'h00000004);
    done_pulse;
    host_read(8'd3, rd); check("post_rst_done", rd, 32'h00000005);
    host_read(8'd0, rd); check("post_rst_mem", rd, 32'd0);
    check("post_rst_shift_y", SHIFT_Y, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
